// File: rtl/key_search_pkg.sv
// Shared types and defaults for the key-search sequencer.
package key_search_pkg;

  localparam int KEY_W_DEFAULT       = 16;
  localparam int TIMEOUT_CYC_DEFAULT = 64;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_FOUND   = 3'd3,
    ST_EXHAUST = 3'd4,
    ST_TERR    = 3'd5
  } key_search_state_t;

endpackage

// File: rtl/key_range_counter.sv
// Loadable candidate-key counter holding the inclusive upper bound of the range.
module key_range_counter
  import key_search_pkg::*;
#(
  parameter int KEY_W = KEY_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [KEY_W-1:0] lo_i,
  input  logic [KEY_W-1:0] hi_i,
  input  logic             inc_i,
  output logic [KEY_W-1:0] key_o,
  output logic             at_limit_o
);

  logic [KEY_W-1:0] key_q, key_d;
  logic [KEY_W-1:0] hi_q, hi_d;

  // NOTE: defaults first so every path assigns key_d/hi_d and no latch is inferred.
  always_comb begin
    key_d = key_q;
    hi_d  = hi_q;
    if (load_i) begin
      key_d = lo_i;
      hi_d  = hi_i;
    end else if (inc_i) begin
      key_d = key_q + 1'b1;
    end
  end

  // NOTE: <= so every register samples pre-edge values regardless of block order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_q <= '0;
      hi_q  <= '0;
    end else begin
      key_q <= key_d;
      hi_q  <= hi_d;
    end
  end

  assign key_o      = key_q;
  assign at_limit_o = (key_q == hi_q);

endmodule

// File: rtl/key_search_ctrl.sv
// Handshaked, range-bounded brute-force key scheduler in front of a cipher core.
// Optional core watchdog (TERR state) enabled by defining KEY_SEARCH_WATCHDOG_EN.
module key_search_ctrl
  import key_search_pkg::*;
#(
  parameter int KEY_W       = KEY_W_DEFAULT,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [KEY_W-1:0] key_lo,
  input  logic [KEY_W-1:0] key_hi,
  output logic             core_req,
  output logic [KEY_W-1:0] core_key,
  input  logic             core_ready,
  input  logic             core_done,
  input  logic             match,
  output logic             busy,
  output logic             found,
  output logic             exhausted,
  output logic [KEY_W-1:0] found_key,
  output logic [KEY_W:0]   keys_tried,
  output logic             timeout_err
);

  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 1");
  end

  key_search_state_t state_q, state_d;
  logic [KEY_W-1:0]  found_key_q, found_key_d;
  logic [KEY_W:0]    tried_q, tried_d;
  logic              load, inc, at_limit;
  logic [KEY_W-1:0]  cur_key;

`ifdef KEY_SEARCH_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);
  logic [WD_W-1:0] wd_q, wd_d;
`endif

  key_range_counter #(.KEY_W(KEY_W)) u_range (
    .clk       (clk),
    .reset     (reset),
    .load_i    (load),
    .lo_i      (key_lo),
    .hi_i      (key_hi),
    .inc_i     (inc),
    .key_o     (cur_key),
    .at_limit_o(at_limit)
  );

  always_comb begin
    state_d     = state_q;
    found_key_d = found_key_q;
    tried_d     = tried_q;
    load        = 1'b0;
    inc         = 1'b0;
`ifdef KEY_SEARCH_WATCHDOG_EN
    wd_d        = wd_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          load        = 1'b1;
          found_key_d = '0;
          tried_d     = '0;
          state_d     = (key_lo > key_hi) ? ST_EXHAUST : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (core_ready) begin
          state_d = ST_WAIT;
`ifdef KEY_SEARCH_WATCHDOG_EN
          wd_d    = '0;
`endif
        end
      end
      ST_WAIT: begin
        // A done in the expiry cycle wins over the watchdog.
        if (core_done) begin
          tried_d = tried_q + 1'b1;
          if (match) begin
            found_key_d = cur_key;
            state_d     = ST_FOUND;
          end else if (at_limit) begin
            state_d = ST_EXHAUST;
          end else begin
            inc     = 1'b1;
            state_d = ST_ISSUE;
          end
        end
`ifdef KEY_SEARCH_WATCHDOG_EN
        else if (wd_q == WD_LAST) begin
          state_d = ST_TERR;
        end else begin
          wd_d = wd_q + 1'b1;
        end
`endif
      end
      ST_FOUND, ST_EXHAUST, ST_TERR: begin
        if (!start) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      found_key_q <= '0;
      tried_q     <= '0;
    end else begin
      state_q     <= state_d;
      found_key_q <= found_key_d;
      tried_q     <= tried_d;
    end
  end

`ifdef KEY_SEARCH_WATCHDOG_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) wd_q <= '0;
    else       wd_q <= wd_d;
  end
  assign timeout_err = (state_q == ST_TERR);
`else
  assign timeout_err = 1'b0;
`endif

  // Status decodes straight from the state register so reset clears them at once.
  assign core_req   = (state_q == ST_ISSUE);
  assign busy       = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
  assign found      = (state_q == ST_FOUND);
  assign exhausted  = (state_q == ST_EXHAUST);
  assign core_key   = cur_key;
  assign found_key  = found_key_q;
  assign keys_tried = tried_q;

endmodule

// File: tb/tb_key_search_ctrl.sv
// Directed, table-driven bench for key_search_ctrl with a behavioural cipher-core model.
module tb_key_search_ctrl;

  localparam int KW = 8;

  logic          clk = 1'b0;
  logic          reset, start;
  logic [KW-1:0] key_lo, key_hi;
  logic          core_req;
  logic [KW-1:0] core_key;
  logic          core_ready, core_done, match;
  logic          busy, found, exhausted;
  logic [KW-1:0] found_key;
  logic [KW:0]   keys_tried;
  logic          timeout_err;

  key_search_ctrl #(.KEY_W(KW), .TIMEOUT_CYC(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .key_lo     (key_lo),
    .key_hi     (key_hi),
    .core_req   (core_req),
    .core_key   (core_key),
    .core_ready (core_ready),
    .core_done  (core_done),
    .match      (match),
    .busy       (busy),
    .found      (found),
    .exhausted  (exhausted),
    .found_key  (found_key),
    .keys_tried (keys_tried),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Core model state
  bit            ready_en, core_hang, match_en, saw_zero;
  logic [KW-1:0] match_key, pend_key;
  int            done_lat, pend_cnt, hs_cnt;

  typedef struct {
    logic [KW-1:0] lo, hi, mkey;
    bit            men;
    int            lat;
    bit            e_found, e_exh;
    logic [KW-1:0] e_key;
    int            e_tried, e_hs, e_cyc;
    bit            e_zero;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One cycle: wait for the falling edge, then play the core's side of the handshake.
  task automatic tick();
    @(negedge clk);
    core_done = 1'b0;
    match     = 1'b0;
    if (pend_cnt > 0) begin
      pend_cnt--;
      if (pend_cnt == 0 && !core_hang) begin
        core_done = 1'b1;
        match     = match_en && (pend_key == match_key);
      end
    end
    core_ready = ready_en;
    if (core_req && core_ready) begin
      hs_cnt++;
      pend_key = core_key;
      pend_cnt = done_lat;
      if (core_key == '0) saw_zero = 1'b1;
    end
  endtask

  task automatic launch(input logic [KW-1:0] lo, input logic [KW-1:0] hi,
                        input logic [KW-1:0] mk, input bit men, input int lat, input bit hang);
    key_lo    = lo;
    key_hi    = hi;
    match_key = mk;
    match_en  = men;
    done_lat  = lat;
    core_hang = hang;
    hs_cnt    = 0;
    saw_zero  = 1'b0;
    pend_cnt  = 0;
    start     = 1'b1;
  endtask

  task automatic run_until(input int budget, output int cycles);
    bit term = 1'b0;
    cycles = 0;
    while (!term && cycles < budget) begin
      tick();
      cycles++;
      term = found | exhausted | timeout_err;
    end
    check("terminal_reached", found | exhausted | timeout_err, 1);
  endtask

  initial begin
    int cyc;
    vecs[0] = '{8'h10, 8'h1F, 8'h14, 1'b1, 3, 1'b1, 1'b0, 8'h14, 5, 5, 21, 1'b0};
    vecs[1] = '{8'hF0, 8'hFF, 8'h00, 1'b0, 3, 1'b0, 1'b1, 8'h00, 16, 16, 65, 1'b0};
    vecs[2] = '{8'h20, 8'h1F, 8'h00, 1'b0, 3, 1'b0, 1'b1, 8'h00, 0, 0, 1, 1'b0};
    vecs[3] = '{8'h00, 8'h03, 8'h03, 1'b1, 1, 1'b1, 1'b0, 8'h03, 4, 4, 9, 1'b1};
    vecs[4] = '{8'h7F, 8'h7F, 8'h7F, 1'b1, 2, 1'b1, 1'b0, 8'h7F, 1, 1, 4, 1'b0};
    vecs[5] = '{8'hFF, 8'hFF, 8'h00, 1'b0, 1, 1'b0, 1'b1, 8'h00, 1, 1, 3, 1'b0};

    reset = 1'b1; start = 1'b0; key_lo = '0; key_hi = '0;
    core_ready = 1'b0; core_done = 1'b0; match = 1'b0;
    ready_en = 1'b1; core_hang = 1'b0; match_en = 1'b0; saw_zero = 1'b0;
    match_key = '0; pend_key = '0; done_lat = 1; pend_cnt = 0; hs_cnt = 0;

    repeat (2) @(negedge clk);
    check("rst core_req", core_req, 0);
    check("rst core_key", core_key, 0);
    check("rst busy", busy, 0);
    check("rst found", found, 0);
    check("rst exhausted", exhausted, 0);
    check("rst found_key", found_key, 0);
    check("rst keys_tried", keys_tried, 0);
    check("rst timeout_err", timeout_err, 0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) begin
      launch(vecs[i].lo, vecs[i].hi, vecs[i].mkey, vecs[i].men, vecs[i].lat, 1'b0);
      run_until(200, cyc);
      check($sformatf("v%0d cycles", i), cyc, vecs[i].e_cyc);
      check($sformatf("v%0d found", i), found, vecs[i].e_found);
      check($sformatf("v%0d exhausted", i), exhausted, vecs[i].e_exh);
      check($sformatf("v%0d found_key", i), found_key, vecs[i].e_key);
      check($sformatf("v%0d keys_tried", i), keys_tried, vecs[i].e_tried);
      check($sformatf("v%0d handshakes", i), hs_cnt, vecs[i].e_hs);
      check($sformatf("v%0d key0_issued", i), saw_zero, vecs[i].e_zero);
      check($sformatf("v%0d busy", i), busy, 0);
      tick();
      check($sformatf("v%0d hold found", i), found, vecs[i].e_found);
      check($sformatf("v%0d hold exhausted", i), exhausted, vecs[i].e_exh);
      start = 1'b0;
      tick();
      check($sformatf("v%0d idle flags", i), {busy, found, exhausted}, 0);
      check($sformatf("v%0d idle keys_tried", i), keys_tried, vecs[i].e_tried);
      check($sformatf("v%0d idle found_key", i), found_key, vecs[i].e_key);
    end

    // Core stalls ready for 4 cycles; request and key must hold, range edits ignored.
    ready_en = 1'b0;
    launch(8'h10, 8'h11, 8'h10, 1'b1, 2, 1'b0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("stall%0d core_req", k), core_req, 1);
      check($sformatf("stall%0d core_key", k), core_key, 8'h10);
      key_lo = 8'h00;
      key_hi = 8'hFF;
    end
    check("stall no accept", hs_cnt, 0);
    ready_en = 1'b1;
    run_until(50, cyc);
    check("stall cycles", cyc, 4);
    check("stall found", found, 1);
    check("stall found_key", found_key, 8'h10);
    check("stall keys_tried", keys_tried, 1);
    check("stall handshakes", hs_cnt, 1);
    start = 1'b0;
    tick();

    // Reset in the middle of WAIT, then a fresh search.
    launch(8'h40, 8'h50, 8'h00, 1'b0, 1, 1'b0);
    repeat (6) tick();
    check("midwait keys_tried", keys_tried, 2);
    check("midwait core_key", core_key, 8'h42);
    check("midwait busy", busy, 1);
    check("midwait core_req", core_req, 0);
    reset = 1'b1; start = 1'b0; core_done = 1'b0; match = 1'b0; pend_cnt = 0;
    #1;
    check("arst core_req", core_req, 0);
    check("arst core_key", core_key, 0);
    check("arst busy", busy, 0);
    check("arst flags", {found, exhausted, timeout_err}, 0);
    check("arst found_key", found_key, 0);
    check("arst keys_tried", keys_tried, 0);
    tick();
    reset = 1'b0;
    launch(8'h00, 8'h02, 8'h00, 1'b0, 2, 1'b0);
    run_until(100, cyc);
    check("restart cycles", cyc, 10);
    check("restart exhausted", exhausted, 1);
    check("restart keys_tried", keys_tried, 3);
    check("restart handshakes", hs_cnt, 3);
    start = 1'b0;
    tick();

    // Core never answers.
    launch(8'h30, 8'h3F, 8'h00, 1'b0, 1, 1'b1);
`ifdef KEY_SEARCH_WATCHDOG_EN
    run_until(40, cyc);
    check("wd cycles", cyc, 10);
    check("wd timeout_err", timeout_err, 1);
    check("wd keys_tried", keys_tried, 0);
    check("wd core_req", core_req, 0);
    check("wd busy", busy, 0);
    start = 1'b0;
    tick();
    check("wd idle timeout_err", timeout_err, 0);
    check("wd idle busy", busy, 0);
`else
    repeat (30) tick();
    check("hang busy", busy, 1);
    check("hang timeout_err", timeout_err, 0);
    check("hang keys_tried", keys_tried, 0);
    check("hang core_req", core_req, 0);
    reset = 1'b1; start = 1'b0; pend_cnt = 0;
    tick();
    reset = 1'b0;
`endif
    tick();

    // Reset while a request is outstanding drops core_req at once.
    ready_en = 1'b0;
    launch(8'h55, 8'h60, 8'h00, 1'b0, 1, 1'b0);
    tick();
    check("issue core_req", core_req, 1);
    check("issue core_key", core_key, 8'h55);
    reset = 1'b1;
    start = 1'b0;
    #1;
    check("issue arst core_req", core_req, 0);
    check("issue arst core_key", core_key, 0);
    tick();
    reset = 1'b0;
    ready_en = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
